// File: rtl/qpix_readout_pkg.sv
// Shared definitions for the channel-FIFO readout path: state encoding,
// channel index width helper and default timestamp word width.
package qpix_readout_pkg;

  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } drain_state_t;

  // Bits needed to index n items; never less than 1.
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << w) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// at or after ptr, wrapping modulo N_CH.
module rr_pick
  import qpix_readout_pkg::*;
#(
  parameter  int N_CH = 16,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  logic [CH_W-1:0] w_idx [N_CH];
  logic [N_CH-1:0] w_rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      // N_CH is a power of two, so the CH_W-bit sum wraps for free.
      assign w_idx[gi] = ptr + CH_W'(gi);
      assign w_rot[gi] = req[w_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) grant = w_idx[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of per-channel timestamp FIFOs into one tagged word
// stream: one rd_en pulse per word, word held until the consumer takes it.
module fifo_drain_arbiter
  import qpix_readout_pkg::*;
#(
  parameter  int N_CH   = 16,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int RD_LAT = 1,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [N_CH-1:0]          ch_empty,
  input  logic [N_CH*DATA_W-1:0]   ch_dout,
  output logic [N_CH-1:0]          ch_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [31:0]              word_count,
  output logic                     busy
);

  localparam int CNT_W = ch_width(RD_LAT + 1);

  drain_state_t      r_state, w_state_next;
  logic [CH_W-1:0]   r_grant, r_ptr, r_out_ch;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_CH-1:0]   r_rd_en;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [31:0]       r_word_count;

  logic [N_CH-1:0]   w_req;
  logic [CH_W-1:0]   w_grant;
  logic              w_any, w_accept, w_cnt_last;

  assign w_req      = ~ch_empty & ch_mask & {N_CH{enable}};
  assign w_accept   = r_out_valid & out_ready;
  assign w_cnt_last = (r_cnt == CNT_W'(1));

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any)      w_state_next = ST_READ;
      ST_READ:                 w_state_next = ST_WAIT;
      ST_WAIT: if (w_cnt_last) w_state_next = ST_HOLD;
      ST_HOLD: if (w_accept)   w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_rd_en      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_rd_en <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_grant;
            r_rd_en <= N_CH'(1) << w_grant;
          end
        end
        ST_READ: r_cnt <= CNT_W'(RD_LAT);
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // FIFO output is valid on the last wait cycle; capture it here.
          if (w_cnt_last) begin
            r_out_data  <= ch_dout[r_grant*DATA_W +: DATA_W];
            r_out_ch    <= r_grant;
            r_out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_out_valid  <= 1'b0;
            r_ptr        <= r_grant + CH_W'(1);
            r_word_count <= r_word_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_rd_en   = r_rd_en;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ch     = r_out_ch;
  assign word_count = r_word_count;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFO models per channel, a transaction-level
// reference checked every cycle, directed scenarios and a random phase.
module tb_fifo_drain_arbiter;

  localparam int N_CH   = 16;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 1;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic [N_CH-1:0]        ch_mask;
  logic [N_CH-1:0]        ch_empty;
  logic [N_CH*DATA_W-1:0] ch_dout;
  logic [N_CH-1:0]        ch_rd_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [3:0]             out_ch;
  logic [31:0]            word_count;
  logic                   busy;

  fifo_drain_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .ch_empty   (ch_empty),
    .ch_dout    (ch_dout),
    .ch_rd_en   (ch_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .word_count (word_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel FIFO models (first-word read latency of one cycle)
  logic [DATA_W-1:0] mem [N_CH][64];
  int                wr_p [N_CH];
  int                rd_p [N_CH];
  logic [DATA_W-1:0] dout_r [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_fifo
      assign ch_empty[gi] = (wr_p[gi] == rd_p[gi]);
      assign ch_dout[gi*DATA_W +: DATA_W] = dout_r[gi];
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) rd_p[i] <= wr_p[i];
      else if (ch_rd_en[i] && rd_p[i] != wr_p[i]) begin
        dout_r[i] <= mem[i][rd_p[i] % 64];
        rd_p[i]   <= rd_p[i] + 1;
      end
    end
  end

  // Reference model state
  bit                m_busy;
  int                m_t, m_ch, m_ptr;
  logic [DATA_W-1:0] m_data, m_out_data;
  logic [3:0]        m_out_ch;
  logic [31:0]       m_count;

  int n_checks, n_pass, cyc, n_xfer;
  logic              s_valid, s_busy;
  logic [N_CH-1:0]   s_rd;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_ch;
  logic [31:0]       s_count;

  int                rd_cyc[$];
  logic [N_CH-1:0]   rd_vec[$];
  int                acc_cyc[$];
  int                acc_ch[$];
  logic [DATA_W-1:0] acc_data[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic int rr_ref(input logic [N_CH-1:0] req, input int ptr);
    for (int k = 0; k < N_CH; k++)
      if (req[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_ch = 0; m_ptr = 0;
    m_data = '0; m_out_data = '0; m_out_ch = '0; m_count = '0;
  endtask

  // One cycle: compare at the falling edge, advance model, return after next rise.
  task automatic tick();
    logic [N_CH-1:0] exp_rd, req;
    logic            exp_valid;
    @(negedge clk);
    cyc++;
    exp_rd    = (m_busy && m_t == 0) ? (N_CH'(1) << m_ch) : '0;
    exp_valid = m_busy && (m_t >= RD_LAT + 1);
    chk("ch_rd_en",    64'(ch_rd_en),   64'(exp_rd));
    chk("out_valid",   64'(out_valid),  64'(exp_valid));
    chk("out_data",    out_data,        m_out_data);
    chk("out_ch",      64'(out_ch),     64'(m_out_ch));
    chk("word_count",  64'(word_count), 64'(m_count));
    chk("busy",        64'(busy),       64'(m_busy));
    chk("rd_on_empty", 64'(ch_rd_en & ch_empty), 64'd0);
    s_valid = out_valid; s_busy = busy; s_rd = ch_rd_en;
    s_data = out_data; s_ch = out_ch; s_count = word_count;
    if (ch_rd_en != '0) begin rd_cyc.push_back(cyc); rd_vec.push_back(ch_rd_en); end
    if (out_valid && out_ready) begin
      acc_cyc.push_back(cyc); acc_ch.push_back(int'(out_ch)); acc_data.push_back(out_data);
      n_xfer++;
      $display("xfer %0d: ch %0d data %h cycle %0d", n_xfer, out_ch, out_data, cyc);
    end
    req = ~ch_empty & ch_mask & {N_CH{enable}};
    if (rst) model_reset();
    else if (!m_busy) begin
      if (req != '0) begin
        m_ch   = rr_ref(req, m_ptr);
        m_data = mem[m_ch][rd_p[m_ch] % 64];
        m_busy = 1; m_t = 0;
      end
    end else if (exp_valid && out_ready) begin
      m_busy = 0; m_ptr = (m_ch + 1) % N_CH; m_count = m_count + 32'd1;
    end else begin
      m_t++;
      if (m_t == RD_LAT + 1) begin m_out_data = m_data; m_out_ch = 4'(m_ch); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] d);
    mem[ch][wr_p[ch] % 64] = d;
    wr_p[ch]++;
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); rd_vec.delete(); acc_cyc.delete(); acc_ch.delete(); acc_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int max);
    for (int k = 0; k < max; k++) begin
      tick();
      if (s_valid) return;
    end
    n_checks++;
    $display("FAIL %s: out_valid not seen within %0d cycles", nm, max);
  endtask

  task automatic wait_rd(input string nm, input int max);
    for (int k = 0; k < max; k++) begin
      tick();
      if (s_rd != '0) return;
    end
    n_checks++;
    $display("FAIL %s: ch_rd_en not seen within %0d cycles", nm, max);
  endtask

  function automatic int ch_at(input int k);
    return (k < acc_ch.size()) ? acc_ch[k] : 99;
  endfunction

  initial begin
    int t0, rd_bit0, drained;
    int exp_rr[6];
    exp_rr = '{0, 5, 15, 0, 5, 15};
    for (int i = 0; i < N_CH; i++) wr_p[i] = 0;
    n_checks = 0; n_pass = 0; cyc = 0; n_xfer = 0;
    model_reset();
    rst = 1'b1; enable = 1'b1; ch_mask = '1; out_ready = 1'b1;
    run(2);
    rst = 1'b0;
    chk("reset_valid", 64'(s_valid), 64'd0);
    chk("reset_data",  s_data, 64'd0);
    chk("reset_count", 64'(s_count), 64'd0);
    chk("reset_busy",  64'(s_busy), 64'd0);

    // Single channel
    clear_logs();
    push(2, 64'h0000_0000_0000_1234);
    t0 = cyc + 1;
    run(8);
    chk("single_rd_cnt",  64'(rd_vec.size()), 64'd1);
    chk("single_rd_vec",  64'((rd_vec.size() > 0) ? rd_vec[0] : '0), 64'h0004);
    chk("single_rd_cyc",  64'((rd_cyc.size() > 0) ? rd_cyc[0] - t0 : -1), 64'd1);
    chk("single_val_cyc", 64'((acc_cyc.size() > 0) ? acc_cyc[0] - t0 : -1), 64'd3);
    chk("single_data",    (acc_data.size() > 0) ? acc_data[0] : '1, 64'h1234);
    chk("single_ch",      64'(ch_at(0)), 64'd2);
    chk("single_count",   64'(s_count), 64'd1);

    // Round-robin from a fresh pointer
    do_reset();
    clear_logs();
    for (int k = 0; k < 2; k++) begin
      push(0, 64'hA000 + 64'(k)); push(5, 64'hA050 + 64'(k)); push(15, 64'hA0F0 + 64'(k));
    end
    run(40);
    for (int k = 0; k < 6; k++) chk("rr_order", 64'(ch_at(k)), 64'(exp_rr[k]));
    chk("rr_last_data", (acc_data.size() > 5) ? acc_data[5] : '1, 64'hA0F1);
    chk("rr_count", 64'(s_count), 64'd6);

    // Backpressure
    out_ready = 1'b0;
    push(3, 64'hB3); push(7, 64'hB7);
    wait_valid("bp", 20);
    clear_logs();
    run(20);
    chk("bp_no_rd", 64'(rd_vec.size()), 64'd0);
    chk("bp_data",  s_data, 64'hB3);
    chk("bp_ch",    64'(s_ch), 64'd3);
    out_ready = 1'b1;
    run(10);
    chk("bp_next_rd", 64'((rd_vec.size() > 0) ? rd_vec[0] : '0), 64'h0080);
    chk("bp_first",   64'(ch_at(0)), 64'd3);
    chk("bp_second",  64'(ch_at(1)), 64'd7);

    // Mask and enable
    ch_mask = 16'hFFFE;
    clear_logs();
    push(0, 64'hC0); push(1, 64'hC1);
    run(12);
    rd_bit0 = 0;
    foreach (rd_vec[k]) rd_bit0 |= int'(rd_vec[k][0]);
    chk("mask_ch0_unread", 64'(rd_bit0), 64'd0);
    chk("mask_ch1", 64'(ch_at(0)), 64'd1);
    clear_logs();
    push(6, 64'hC6);
    wait_rd("en", 20);
    enable = 1'b0;
    push(8, 64'hC8);
    run(10);
    chk("en_done_ch",  64'(ch_at(0)), 64'd6);
    chk("en_done_dat", (acc_data.size() > 0) ? acc_data[0] : '1, 64'hC6);
    chk("en_rd_cnt",   64'(rd_vec.size()), 64'd1);
    chk("en_busy",     64'(s_busy), 64'd0);
    enable = 1'b1; ch_mask = '1;
    clear_logs();
    run(16);
    chk("en_resume_a", 64'(ch_at(0)), 64'd8);
    chk("en_resume_b", 64'(ch_at(1)), 64'd0);

    // Pointer wrap and counter wrap
    do_reset();
    push(15, 64'hD15);
    run(8);
    clear_logs();
    push(0, 64'hD00); push(15, 64'hD1F);
    run(12);
    chk("wrap_first",  64'(ch_at(0)), 64'd0);
    chk("wrap_second", 64'(ch_at(1)), 64'd15);
    force dut.r_word_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    release dut.r_word_count;
    push(5, 64'hD05);
    run(8);
    chk("count_wrap", 64'(s_count), 64'd0);

    // Reset while holding a word
    out_ready = 1'b0;
    push(9, 64'hE9);
    wait_valid("rst_hold", 20);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("rst_rd",    64'(s_rd), 64'd0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_data",  s_data, 64'd0);
    chk("rst_ch",    64'(s_ch), 64'd0);
    chk("rst_count", 64'(s_count), 64'd0);
    chk("rst_busy",  64'(s_busy), 64'd0);
    out_ready = 1'b1;
    clear_logs();
    push(0, 64'hE0); push(8, 64'hE8);
    run(12);
    chk("rst_restart_a", 64'(ch_at(0)), 64'd0);
    chk("rst_restart_b", 64'(ch_at(1)), 64'd8);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(95, 0) == 0 && (wr_p[i] - rd_p[i]) < 50)
          push(i, {32'(i), 32'($urandom)});
      ch_mask   = ($urandom_range(9, 0) == 0) ? N_CH'($urandom) : '1;
      enable    = ($urandom_range(19, 0) != 0);
      out_ready = ($urandom_range(9, 0) < 7);
      tick();
    end
    enable = 1'b1; ch_mask = '1; out_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 4000 && !drained; c++) begin
      tick();
      drained = (ch_empty == '1) && !m_busy;
    end
    if (!drained) begin
      n_checks++;
      $display("FAIL drain: FIFOs not emptied within 4000 cycles");
    end
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
